// File: rtl/breakpoint_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// breakpoint_ctrl_pkg
// Shared debug types for the hardware breakpoint unit.
//   bp_cmd_t       : breakpoint table command opcodes
//   bp_state_t     : halt sequencer states
//   BP_NUM_DEFAULT : default number of breakpoint slots
// -----------------------------------------------------------------------------
package breakpoint_ctrl_pkg;

    localparam int unsigned BP_NUM_DEFAULT = 8;

    typedef enum logic [1:0] {
        BP_ADD    = 2'd0,
        BP_REMOVE = 2'd1,
        BP_CLEAR  = 2'd2
    } bp_cmd_t;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        HALTED = 3'd3,
        SKIP   = 3'd4
    } bp_state_t;

endpackage

// File: rtl/breakpoint_ctrl_table.sv
// -----------------------------------------------------------------------------
// bp_table
// Breakpoint slot storage with lookup encoders.
//   clk, reset        : clock, synchronous active-high reset
//   i_wr_en/idx/addr  : write a valid entry into a slot
//   i_clr_en/idx      : invalidate one slot
//   i_clr_all         : invalidate every slot
//   i_pc, i_pc_valid  : fetched PC for breakpoint matching
//   i_lookup_addr     : command address for duplicate / remove lookup
//   o_match/_idx      : lowest valid slot whose address equals i_pc
//   o_free/_idx       : lowest invalid slot
//   o_present/_idx    : lowest valid slot whose address equals i_lookup_addr
//   o_count           : number of valid slots
// -----------------------------------------------------------------------------
module bp_table
    import breakpoint_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_BP = BP_NUM_DEFAULT,
    parameter  int unsigned ADDR_W = 32,
    localparam int unsigned IDX_W  = $clog2(NUM_BP),
    localparam int unsigned CNT_W  = IDX_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_clr_en,
    input  logic [IDX_W-1:0]  i_clr_idx,
    input  logic              i_clr_all,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_pc_valid,
    input  logic [ADDR_W-1:0] i_lookup_addr,
    output logic              o_match,
    output logic [IDX_W-1:0]  o_match_idx,
    output logic              o_free,
    output logic [IDX_W-1:0]  o_free_idx,
    output logic              o_present,
    output logic [IDX_W-1:0]  o_present_idx,
    output logic [CNT_W-1:0]  o_count
);

    logic [NUM_BP-1:0] r_vld;
    logic [ADDR_W-1:0] r_addr [NUM_BP];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
        end else if (i_clr_all) begin
            r_vld <= '0;
        end else begin
            if (i_wr_en)  r_vld[i_wr_idx]  <= 1'b1;
            if (i_clr_en) r_vld[i_clr_idx] <= 1'b0;
        end
    end

    // Address storage is qualified by r_vld, so it needs no reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_addr[i_wr_idx] <= i_wr_addr;
    end

    // Ascending scans; the first hit found is kept so the lowest index wins.
    always_comb begin
        o_match       = 1'b0;
        o_match_idx   = '0;
        o_free        = 1'b0;
        o_free_idx    = '0;
        o_present     = 1'b0;
        o_present_idx = '0;
        o_count       = '0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (!o_match && i_pc_valid && r_vld[i] && (r_addr[i] == i_pc)) begin
                o_match     = 1'b1;
                o_match_idx = IDX_W'(i);
            end
            if (!o_free && !r_vld[i]) begin
                o_free     = 1'b1;
                o_free_idx = IDX_W'(i);
            end
            if (!o_present && r_vld[i] && (r_addr[i] == i_lookup_addr)) begin
                o_present     = 1'b1;
                o_present_idx = IDX_W'(i);
            end
            o_count = o_count + CNT_W'(r_vld[i]);
        end
    end

endmodule

// File: rtl/breakpoint_ctrl.sv
// -----------------------------------------------------------------------------
// breakpoint_ctrl
// Hardware PC breakpoint unit: command-driven breakpoint table plus a halt
// sequencer that pauses the MCU via the pause / in_valid / mcu_busy handshake.
//   clk, reset            : clock, synchronous active-high reset
//   i_cmd_valid/op/addr   : table command request (add / remove / clear)
//   o_cmd_ready           : command accepted this cycle when high
//   o_cmd_done, o_cmd_err : registered completion pulse and reject flag
//   i_pc, i_pc_valid      : fetched MCU PC
//   i_mcu_busy            : MCU busy acknowledge
//   i_resume              : MCU resumed pulse from the debug controller
//   o_bp_pause            : pause request to the MCU
//   o_bp_in_valid         : qualifier for o_bp_pause
//   o_hit, o_hit_idx      : halted on a breakpoint, and the slot responsible
//   o_bp_count, o_bp_full : valid slot count, table full
// -----------------------------------------------------------------------------
module breakpoint_ctrl
    import breakpoint_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_BP = BP_NUM_DEFAULT,
    parameter  int unsigned ADDR_W = 32,
    localparam int unsigned IDX_W  = $clog2(NUM_BP),
    localparam int unsigned CNT_W  = IDX_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_cmd_valid,
    input  bp_cmd_t           i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    output logic              o_cmd_ready,
    output logic              o_cmd_done,
    output logic              o_cmd_err,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_pc_valid,
    input  logic              i_mcu_busy,
    input  logic              i_resume,
    output logic              o_bp_pause,
    output logic              o_bp_in_valid,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_hit_idx,
    output logic [CNT_W-1:0]  o_bp_count,
    output logic              o_bp_full
);

    logic              r_cmd_ready;
    logic              r_cmd_done;
    logic              r_cmd_err;
    bp_state_t         r_state;
    logic              r_bp_pause;
    logic              r_hit;
    logic [IDX_W-1:0]  r_hit_idx;
    logic [ADDR_W-1:0] r_halt_pc;

    logic              w_accept;
    logic              w_err;
    logic              w_wr_en;
    logic              w_clr_en;
    logic              w_clr_all;
    logic              w_match;
    logic [IDX_W-1:0]  w_match_idx;
    logic              w_free;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_present;
    logic [IDX_W-1:0]  w_present_idx;
    logic [CNT_W-1:0]  w_count;

    bp_table #(
        .NUM_BP (NUM_BP),
        .ADDR_W (ADDR_W)
    ) u_table (
        .clk           (clk),
        .reset         (reset),
        .i_wr_en       (w_wr_en),
        .i_wr_idx      (w_free_idx),
        .i_wr_addr     (i_cmd_addr),
        .i_clr_en      (w_clr_en),
        .i_clr_idx     (w_present_idx),
        .i_clr_all     (w_clr_all),
        .i_pc          (i_pc),
        .i_pc_valid    (i_pc_valid),
        .i_lookup_addr (i_cmd_addr),
        .o_match       (w_match),
        .o_match_idx   (w_match_idx),
        .o_free        (w_free),
        .o_free_idx    (w_free_idx),
        .o_present     (w_present),
        .o_present_idx (w_present_idx),
        .o_count       (w_count)
    );

    // ---------------------------------------------------------------- commands
    assign w_accept = i_cmd_valid && r_cmd_ready;

    always_comb begin
        w_err     = 1'b0;
        w_wr_en   = 1'b0;
        w_clr_en  = 1'b0;
        w_clr_all = 1'b0;
        case (i_cmd_op)
            BP_ADD: begin
                w_err   = (i_cmd_addr[1:0] != 2'b00) || !w_free || w_present;
                w_wr_en = w_accept && !w_err;
            end
            BP_REMOVE: begin
                w_err    = !w_present;
                w_clr_en = w_accept && w_present;
            end
            BP_CLEAR: begin
                w_clr_all = w_accept;
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    // One command per two cycles: ready drops for the completion cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_ready <= 1'b1;
            r_cmd_done  <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_cmd_ready <= !w_accept;
            r_cmd_done  <= w_accept;
            r_cmd_err   <= w_accept && w_err;
        end
    end

    // ---------------------------------------------------------------- halt FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_bp_pause <= 1'b0;
            r_hit      <= 1'b0;
            r_hit_idx  <= '0;
            r_halt_pc  <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_match) begin
                        r_state    <= REQ;
                        r_bp_pause <= 1'b1;
                        r_hit_idx  <= w_match_idx;
                        r_halt_pc  <= i_pc;
                    end
                end
                REQ: begin
                    if (i_mcu_busy) begin
                        r_state    <= WAIT;
                        r_bp_pause <= 1'b0;
                    end
                end
                WAIT: begin
                    if (!i_mcu_busy) begin
                        r_state <= HALTED;
                        r_hit   <= 1'b1;
                    end
                end
                HALTED: begin
                    if (i_resume) begin
                        r_state <= SKIP;
                        r_hit   <= 1'b0;
                    end
                end
                SKIP: begin
                    // Leaving SKIP evaluates the new PC like RUN would.
                    if (i_pc_valid && (i_pc != r_halt_pc)) begin
                        if (w_match) begin
                            r_state    <= REQ;
                            r_bp_pause <= 1'b1;
                            r_hit_idx  <= w_match_idx;
                            r_halt_pc  <= i_pc;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_bp_pause <= 1'b0;
                    r_hit      <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_ready   = r_cmd_ready;
    assign o_cmd_done    = r_cmd_done;
    assign o_cmd_err     = r_cmd_err;
    assign o_bp_pause    = r_bp_pause;
    assign o_bp_in_valid = r_bp_pause;
    assign o_hit         = r_hit;
    assign o_hit_idx     = r_hit_idx;
    assign o_bp_count    = w_count;
    assign o_bp_full     = (w_count == CNT_W'(NUM_BP));

endmodule

// File: tb/tb_breakpoint_ctrl.sv
// -----------------------------------------------------------------------------
// tb_breakpoint_ctrl
// Directed self-checking bench for breakpoint_ctrl (NUM_BP=8, ADDR_W=32).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_breakpoint_ctrl;
    import breakpoint_ctrl_pkg::*;

    localparam int unsigned NBP = 8;
    localparam int unsigned AW  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_cmd_valid;
    bp_cmd_t       i_cmd_op;
    logic [AW-1:0] i_cmd_addr;
    logic          o_cmd_ready;
    logic          o_cmd_done;
    logic          o_cmd_err;
    logic [AW-1:0] i_pc;
    logic          i_pc_valid;
    logic          i_mcu_busy;
    logic          i_resume;
    logic          o_bp_pause;
    logic          o_bp_in_valid;
    logic          o_hit;
    logic [2:0]    o_hit_idx;
    logic [3:0]    o_bp_count;
    logic          o_bp_full;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    breakpoint_ctrl #(
        .NUM_BP (NBP),
        .ADDR_W (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_cmd_valid   (i_cmd_valid),
        .i_cmd_op      (i_cmd_op),
        .i_cmd_addr    (i_cmd_addr),
        .o_cmd_ready   (o_cmd_ready),
        .o_cmd_done    (o_cmd_done),
        .o_cmd_err     (o_cmd_err),
        .i_pc          (i_pc),
        .i_pc_valid    (i_pc_valid),
        .i_mcu_busy    (i_mcu_busy),
        .i_resume      (i_resume),
        .o_bp_pause    (o_bp_pause),
        .o_bp_in_valid (o_bp_in_valid),
        .o_hit         (o_hit),
        .o_hit_idx     (o_hit_idx),
        .o_bp_count    (o_bp_count),
        .o_bp_full     (o_bp_full)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, return the completion flags, then idle one cycle.
    task automatic do_cmd(input bp_cmd_t op, input logic [AW-1:0] addr,
                          output logic done, output logic err);
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_addr  = addr;
        tick();
        done        = o_cmd_done;
        err         = o_cmd_err;
        i_cmd_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_op = BP_ADD; i_cmd_addr = '0;
        i_pc = '0; i_pc_valid = 1'b0; i_mcu_busy = 1'b0; i_resume = 1'b0;
        tick(); tick();
        n_tests++; if (o_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", o_cmd_ready); end
        n_tests++; if (o_cmd_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", o_cmd_done); end
        n_tests++; if (o_cmd_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", o_cmd_err); end
        n_tests++; if (o_bp_pause !== 1'b0) begin n_fail++; $display("FAIL rst_pause: got %b want 0", o_bp_pause); end
        n_tests++; if (o_bp_in_valid !== 1'b0) begin n_fail++; $display("FAIL rst_in_valid: got %b want 0", o_bp_in_valid); end
        n_tests++; if (o_hit !== 1'b0) begin n_fail++; $display("FAIL rst_hit: got %b want 0", o_hit); end
        n_tests++; if (o_hit_idx !== 3'd0) begin n_fail++; $display("FAIL rst_hit_idx: got %0d want 0", o_hit_idx); end
        n_tests++; if (o_bp_count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", o_bp_count); end
        n_tests++; if (o_bp_full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", o_bp_full); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add();
        logic d, e;
        do_cmd(BP_ADD, 32'h10, d, e);
        n_tests++; if (d !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL add10_done_err: got %b%b want 10", d, e); end
        n_tests++; if (o_bp_count !== 4'd1) begin n_fail++; $display("FAIL add10_count: got %0d want 1", o_bp_count); end
        do_cmd(BP_ADD, 32'h20, d, e);
        n_tests++; if (d !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL add20_done_err: got %b%b want 10", d, e); end
        n_tests++; if (o_bp_count !== 4'd2) begin n_fail++; $display("FAIL add20_count: got %0d want 2", o_bp_count); end
        do_cmd(BP_ADD, 32'h10, d, e);
        n_tests++; if (d !== 1'b1 || e !== 1'b1) begin n_fail++; $display("FAIL add_dup_err: got %b%b want 11", d, e); end
        n_tests++; if (o_bp_count !== 4'd2) begin n_fail++; $display("FAIL add_dup_count: got %0d want 2", o_bp_count); end
        do_cmd(BP_ADD, 32'h12, d, e);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL add_misaligned_err: got %b want 1", e); end
        n_tests++; if (o_bp_count !== 4'd2) begin n_fail++; $display("FAIL add_misaligned_count: got %0d want 2", o_bp_count); end
    endtask

    task automatic test_full();
        logic d, e;
        do_cmd(BP_CLEAR, 32'h0, d, e);
        n_tests++; if (o_bp_count !== 4'd0) begin n_fail++; $display("FAIL clr0_count: got %0d want 0", o_bp_count); end
        for (int i = 0; i < 8; i++) begin
            do_cmd(BP_ADD, 32'h100 + 32'(4 * i), d, e);
            n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL fill_err[%0d]: got %b want 0", i, e); end
        end
        n_tests++; if (o_bp_count !== 4'd8) begin n_fail++; $display("FAIL fill_count: got %0d want 8", o_bp_count); end
        n_tests++; if (o_bp_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", o_bp_full); end
        do_cmd(BP_ADD, 32'h200, d, e);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL add9_err: got %b want 1", e); end
        n_tests++; if (o_bp_count !== 4'd8) begin n_fail++; $display("FAIL add9_count: got %0d want 8", o_bp_count); end
        do_cmd(BP_REMOVE, 32'h30, d, e);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL rm_absent_err: got %b want 1", e); end
        do_cmd(BP_REMOVE, 32'h104, d, e);
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL rm_104_err: got %b want 0", e); end
        n_tests++; if (o_bp_count !== 4'd7 || o_bp_full !== 1'b0) begin n_fail++; $display("FAIL rm_104_count_full: got %0d/%b want 7/0", o_bp_count, o_bp_full); end
        do_cmd(BP_CLEAR, 32'h0, d, e);
        n_tests++; if (d !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL clr_done_err: got %b%b want 10", d, e); end
        n_tests++; if (o_bp_count !== 4'd0 || o_bp_full !== 1'b0) begin n_fail++; $display("FAIL clr_count_full: got %0d/%b want 0/0", o_bp_count, o_bp_full); end
    endtask

    task automatic test_halt();
        logic d, e;
        do_cmd(BP_ADD, 32'h10, d, e);
        for (int k = 0; k < 4; k++) begin
            i_pc = 32'(4 * k); i_pc_valid = 1'b1;
            tick();
            n_tests++; if (o_bp_pause !== 1'b0) begin n_fail++; $display("FAIL pre_pause[%0d]: got %b want 0", k, o_bp_pause); end
        end
        i_pc = 32'h10;
        tick();
        n_tests++; if (o_bp_pause !== 1'b1 || o_bp_in_valid !== 1'b1) begin n_fail++; $display("FAIL req_pause: got %b%b want 11", o_bp_pause, o_bp_in_valid); end
        n_tests++; if (o_hit !== 1'b0) begin n_fail++; $display("FAIL req_hit: got %b want 0", o_hit); end
        // MCU holds PC at 0x10 and acknowledges with 5 busy cycles.
        i_pc_valid = 1'b0; i_mcu_busy = 1'b1;
        tick();
        n_tests++; if (o_bp_pause !== 1'b0 || o_bp_in_valid !== 1'b0) begin n_fail++; $display("FAIL wait_pause: got %b%b want 00", o_bp_pause, o_bp_in_valid); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++; if (o_hit !== 1'b0) begin n_fail++; $display("FAIL busy_hit[%0d]: got %b want 0", k, o_hit); end
        end
        i_mcu_busy = 1'b0;
        tick();
        n_tests++; if (o_hit !== 1'b1 || o_hit_idx !== 3'd0) begin n_fail++; $display("FAIL halt_hit: got %b/%0d want 1/0", o_hit, o_hit_idx); end
        i_pc_valid = 1'b1;
        tick();
        n_tests++; if (o_bp_pause !== 1'b0 || o_hit !== 1'b1) begin n_fail++; $display("FAIL halted_ignore: got %b/%b want 0/1", o_bp_pause, o_hit); end
        i_pc_valid = 1'b0;
    endtask

    task automatic test_resume();
        i_resume = 1'b1;
        tick();
        i_resume = 1'b0;
        n_tests++; if (o_hit !== 1'b0) begin n_fail++; $display("FAIL resume_hit: got %b want 0", o_hit); end
        i_pc = 32'h10; i_pc_valid = 1'b1;
        tick();
        n_tests++; if (o_bp_pause !== 1'b0) begin n_fail++; $display("FAIL skip_same_pc: got %b want 0", o_bp_pause); end
        i_pc = 32'h14;
        tick();
        n_tests++; if (o_bp_pause !== 1'b0) begin n_fail++; $display("FAIL skip_exit_14: got %b want 0", o_bp_pause); end
        i_pc = 32'h18;
        tick();
        i_pc = 32'h10;
        tick();
        n_tests++; if (o_bp_pause !== 1'b1) begin n_fail++; $display("FAIL rehalt_pause: got %b want 1", o_bp_pause); end
        i_pc_valid = 1'b0; i_mcu_busy = 1'b1;
        tick();
        i_mcu_busy = 1'b0;
        tick();
        n_tests++; if (o_hit !== 1'b1 || o_hit_idx !== 3'd0) begin n_fail++; $display("FAIL rehalt_hit: got %b/%0d want 1/0", o_hit, o_hit_idx); end
        i_resume = 1'b1;
        tick();
        i_resume = 1'b0; i_pc = 32'h14; i_pc_valid = 1'b1;
        tick();
        i_pc_valid = 1'b0;
        // Resume while running has no effect.
        i_resume = 1'b1;
        tick();
        i_resume = 1'b0;
        n_tests++; if (o_hit !== 1'b0 || o_bp_pause !== 1'b0) begin n_fail++; $display("FAIL run_resume: got %b/%b want 0/0", o_hit, o_bp_pause); end
    endtask

    task automatic test_same_cycle();
        logic d, e;
        do_cmd(BP_ADD, 32'h20, d, e);
        n_tests++; if (o_bp_count !== 4'd2) begin n_fail++; $display("FAIL sc_add_count: got %0d want 2", o_bp_count); end
        i_pc = 32'h20; i_pc_valid = 1'b1;
        i_cmd_valid = 1'b1; i_cmd_op = BP_REMOVE; i_cmd_addr = 32'h20;
        tick();
        i_pc_valid = 1'b0; i_cmd_valid = 1'b0;
        n_tests++; if (o_bp_pause !== 1'b1) begin n_fail++; $display("FAIL sc_pause: got %b want 1", o_bp_pause); end
        n_tests++; if (o_cmd_done !== 1'b1 || o_cmd_err !== 1'b0) begin n_fail++; $display("FAIL sc_done_err: got %b%b want 10", o_cmd_done, o_cmd_err); end
        n_tests++; if (o_bp_count !== 4'd1) begin n_fail++; $display("FAIL sc_count: got %0d want 1", o_bp_count); end
        i_mcu_busy = 1'b1;
        tick();
        i_mcu_busy = 1'b0;
        tick();
        n_tests++; if (o_hit !== 1'b1 || o_hit_idx !== 3'd1) begin n_fail++; $display("FAIL sc_hit: got %b/%0d want 1/1", o_hit, o_hit_idx); end
        i_resume = 1'b1;
        tick();
        i_resume = 1'b0; i_pc = 32'h24; i_pc_valid = 1'b1;
        tick();
        i_pc_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic d, e;
        do_cmd(BP_CLEAR, 32'h0, d, e);
        i_cmd_valid = 1'b1; i_cmd_op = BP_ADD; i_cmd_addr = 32'h40;
        tick();
        n_tests++; if (o_cmd_done !== 1'b1 || o_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got done %b ready %b want 1 0", o_cmd_done, o_cmd_ready); end
        i_cmd_addr = 32'h44;
        tick();
        n_tests++; if (o_cmd_done !== 1'b0 || o_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: got done %b ready %b want 0 1", o_cmd_done, o_cmd_ready); end
        n_tests++; if (o_bp_count !== 4'd1) begin n_fail++; $display("FAIL b2b_gap_count: got %0d want 1", o_bp_count); end
        tick();
        i_cmd_valid = 1'b0;
        n_tests++; if (o_cmd_done !== 1'b1 || o_cmd_err !== 1'b0 || o_bp_count !== 4'd2) begin n_fail++; $display("FAIL b2b_second: got done %b err %b count %0d want 1 0 2", o_cmd_done, o_cmd_err, o_bp_count); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic d, e;
        do_cmd(BP_ADD, 32'h10, d, e);
        i_pc = 32'h10; i_pc_valid = 1'b1;
        tick();
        i_pc_valid = 1'b0;
        n_tests++; if (o_bp_pause !== 1'b1) begin n_fail++; $display("FAIL rm_req_pause: got %b want 1", o_bp_pause); end
        i_mcu_busy = 1'b1;
        tick();
        i_mcu_busy = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (o_cmd_ready !== 1'b1 || o_cmd_done !== 1'b0 || o_cmd_err !== 1'b0) begin n_fail++; $display("FAIL rm_cmd_flags: got %b%b%b want 100", o_cmd_ready, o_cmd_done, o_cmd_err); end
        n_tests++; if (o_bp_pause !== 1'b0 || o_bp_in_valid !== 1'b0 || o_hit !== 1'b0 || o_hit_idx !== 3'd0) begin n_fail++; $display("FAIL rm_halt_outs: got %b%b%b/%0d want 000/0", o_bp_pause, o_bp_in_valid, o_hit, o_hit_idx); end
        n_tests++; if (o_bp_count !== 4'd0 || o_bp_full !== 1'b0) begin n_fail++; $display("FAIL rm_table: got %0d/%b want 0/0", o_bp_count, o_bp_full); end
        i_pc = 32'h10; i_pc_valid = 1'b1;
        tick();
        i_pc_valid = 1'b0;
        n_tests++; if (o_bp_pause !== 1'b0) begin n_fail++; $display("FAIL rm_no_halt: got %b want 0", o_bp_pause); end
        tick();
        n_tests++; if (o_bp_pause !== 1'b0 || o_hit !== 1'b0) begin n_fail++; $display("FAIL rm_no_halt2: got %b/%b want 0/0", o_bp_pause, o_hit); end
        // Reset while the pause request is up drops it at that edge.
        do_cmd(BP_ADD, 32'h10, d, e);
        i_pc_valid = 1'b1;
        tick();
        i_pc_valid = 1'b0;
        n_tests++; if (o_bp_pause !== 1'b1) begin n_fail++; $display("FAIL rr_req_pause: got %b want 1", o_bp_pause); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (o_bp_pause !== 1'b0 || o_bp_count !== 4'd0) begin n_fail++; $display("FAIL rr_reset: got %b/%0d want 0/0", o_bp_pause, o_bp_count); end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_full();
        test_halt();
        test_resume();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
